alu_frame_bridge: RTL and testbench

ALU_FRAME_BRIDGE -- requirements
Module: alu_frame_bridge

---
 rtl/alu_frame_pkg.sv | 22 ++
 rtl/frame_timer.sv | 30 +++
 rtl/alu_frame_bridge.sv | 185 ++++++++++++++++++
 tb/tb_alu_frame_bridge.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_frame_pkg.sv
// Shared definitions for the ALU frame bridge: FSM state encoding and the
// opcode values understood by the external ALU.
package alu_frame_pkg;

  typedef enum logic [3:0] {
    IDLE,
    GET_OP,
    GET_A,
    GET_B,
    EXEC,
    LATCH,
    SEND_RES,
    SEND_STAT,
    SEND_ERR
  } state_t;

  localparam logic [5:0] OP_ADD = 6'b100000;
  localparam logic [5:0] OP_SUB = 6'b100010;
  localparam logic [5:0] OP_AND = 6'b100100;
  localparam logic [5:0] OP_OR  = 6'b100101;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout for the frame receiver. Down-counter reloaded on clear;
// expired is the terminal-count compare (counter has reached zero).
module frame_timer #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // Reload on clear, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= CNT_W'(TIMEOUT_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Reset value of zero reads as expired; harmless because IDLE always clears.
  assign expired = (cnt == '0);

endmodule

// File: rtl/alu_frame_bridge.sv
// Bridges a byte-serial FIFO pair to an external ALU: collects a request
// frame, fires the ALU, then streams back the result and a status byte.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | hunt for start byte, discard anything else
// GET_OP    | receive opcode byte, reject if upper bits set
// GET_A     | shift in operand A bytes, MSB first
// GET_B     | shift in operand B bytes, MSB first
// EXEC      | one-cycle alu_start strobe
// LATCH     | register ALU result and flags
// SEND_RES  | write result bytes, MSB first
// SEND_STAT | write status byte {0.., carry, zero}
// SEND_ERR  | write error byte, pulse frame_err
module alu_frame_bridge
  import alu_frame_pkg::*;
#(
  parameter int                 NB_DATA     = 8,
  parameter int                 NB_OPND     = 16,
  parameter int                 NB_OP       = 6,
  parameter logic [NB_DATA-1:0] START_FSM   = 8'hFF,
  parameter int unsigned        TIMEOUT_CYC = 1000000,
  parameter logic [NB_DATA-1:0] ERR_BYTE    = 8'hEE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NB_DATA-1:0] rx_data,
  input  logic               rx_empty,
  output logic               rx_rd,
  input  logic               tx_full,
  output logic               tx_wr,
  output logic [NB_DATA-1:0] tx_data,
  output logic [NB_OPND-1:0] alu_a,
  output logic [NB_OPND-1:0] alu_b,
  output logic [NB_OP-1:0]   alu_op,
  output logic               alu_start,
  input  logic [NB_OPND-1:0] alu_result,
  input  logic               alu_carry,
  input  logic               alu_zero,
  output logic               busy,
  output logic               frame_err
);

  localparam int N     = NB_OPND / NB_DATA;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   byte_cnt;
  logic               cnt_last;
  logic [NB_OPND-1:0] a_q, b_q, res_q;
  logic [NB_OP-1:0]   op_q;
  logic               carry_q, zero_q;
  logic               pop;
  logic               tmr_clear, tmr_exp;

  frame_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .expired (tmr_exp)
  );

  assign cnt_last = (byte_cnt == CNT_W'(N - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and the strobe/byte outputs of each state.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_wr     = 1'b0;
    tx_data   = '0;
    alu_start = 1'b0;
    frame_err = 1'b0;
    tmr_clear = 1'b0;
    case (state)
      IDLE: begin
        tmr_clear = 1'b1;
        if (!rx_empty) begin
          pop = 1'b1;
          if (rx_data == START_FSM) state_nxt = GET_OP;
        end
      end
      GET_OP: begin
        if (tmr_exp) begin
          state_nxt = SEND_ERR;
        end else if (!rx_empty) begin
          pop       = 1'b1;
          tmr_clear = 1'b1;
          if (rx_data[NB_DATA-1:NB_OP] != '0) state_nxt = SEND_ERR;
          else                                state_nxt = GET_A;
        end
      end
      GET_A, GET_B: begin
        if (tmr_exp) begin
          state_nxt = SEND_ERR;
        end else if (!rx_empty) begin
          pop       = 1'b1;
          tmr_clear = 1'b1;
          if (cnt_last) state_nxt = (state == GET_A) ? GET_B : EXEC;
        end
      end
      EXEC: begin
        alu_start = 1'b1;
        state_nxt = LATCH;
      end
      LATCH: state_nxt = SEND_RES;
      SEND_RES: begin
        tx_data = res_q[NB_OPND-1 -: NB_DATA];
        if (!tx_full) begin
          tx_wr = 1'b1;
          if (cnt_last) state_nxt = SEND_STAT;
        end
      end
      SEND_STAT: begin
        tx_data = NB_DATA'({carry_q, zero_q});
        if (!tx_full) begin
          tx_wr     = 1'b1;
          state_nxt = IDLE;
        end
      end
      SEND_ERR: begin
        tx_data = ERR_BYTE;
        if (!tx_full) begin
          tx_wr     = 1'b1;
          frame_err = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: operand shift-in, result latch and result shift-out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: byte_cnt <= '0;
        GET_OP: begin
          byte_cnt <= '0;
          if (pop) op_q <= rx_data[NB_OP-1:0];
        end
        GET_A, GET_B: begin
          if (pop) begin
            if (state == GET_A) a_q <= (a_q << NB_DATA) | NB_OPND'(rx_data);
            else                b_q <= (b_q << NB_DATA) | NB_OPND'(rx_data);
            byte_cnt <= cnt_last ? '0 : byte_cnt + 1'b1;
          end
        end
        LATCH: begin
          res_q   <= alu_result;
          carry_q <= alu_carry;
          zero_q  <= alu_zero;
        end
        SEND_RES: begin
          if (tx_wr) begin
            res_q    <= res_q << NB_DATA;
            byte_cnt <= cnt_last ? '0 : byte_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Pop is gated by reset so a held reset never drains the RX FIFO.
  assign rx_rd  = pop & reset;
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;
  assign busy   = (state != IDLE);

endmodule

// File: tb/tb_alu_frame_bridge.sv
// Scoreboard bench for alu_frame_bridge: stimulus pushes expected response
// bytes into a queue, an independent monitor pops and compares on tx_wr.
module tb_alu_frame_bridge;
  import alu_frame_pkg::*;

  localparam int NB_DATA = 8;
  localparam int NB_OPND = 16;
  localparam int NB_OP   = 6;
  localparam int TO      = 64;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_empty = 1'b1;
  logic               rx_rd;
  logic               tx_full;
  logic               tx_full_dir = 1'b0;
  logic               tx_full_rnd = 1'b0;
  logic               rnd_en = 1'b0;
  logic               tx_wr;
  logic [7:0]         tx_data;
  logic [15:0]        alu_a, alu_b, alu_result;
  logic [5:0]         alu_op;
  logic               alu_start, alu_carry, alu_zero, busy, frame_err;

  logic [7:0]  rx_q[$];
  logic [7:0]  exp_q[$];
  logic [37:0] exp_exec_q[$];
  int checks = 0, failures = 0, tx_count = 0, err_count = 0;

  always #5 clk = ~clk;
  assign tx_full = tx_full_dir | tx_full_rnd;

  alu_frame_bridge #(
    .NB_DATA(NB_DATA), .NB_OPND(NB_OPND), .NB_OP(NB_OP),
    .START_FSM(8'hFF), .TIMEOUT_CYC(TO), .ERR_BYTE(8'hEE)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rx_rd(rx_rd),
    .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .busy(busy), .frame_err(frame_err)
  );

  // ALU behaviour: returns {carry, zero, result}; SUB carry means borrow.
  function automatic logic [17:0] alu_ref(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    s = '0; r = '0; c = 1'b0;
    case (op)
      OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
      OP_SUB: begin r = a - b; c = (a < b); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: r = '0;
    endcase
    return {c, (r == 16'h0), r};
  endfunction

  // External ALU stand-in driven by the bridge's operand outputs.
  always_comb {alu_carry, alu_zero, alu_result} = alu_ref(alu_op, alu_a, alu_b);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // RX FIFO model: head byte and empty flag update after the edge.
  always @(posedge clk) begin
    if (rx_rd && rx_q.size() > 0) void'(rx_q.pop_front());
    rx_empty <= (rx_q.size() == 0);
    rx_data  <= (rx_q.size() > 0) ? rx_q[0] : 8'h00;
  end

  // Random TX back-pressure during the random phase.
  always @(posedge clk) begin
    #1;
    tx_full_rnd = rnd_en ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  // Monitor: compare every written byte and every ALU launch.
  always @(negedge clk) begin
    if (tx_wr) begin
      tx_count++;
      chk("tx_wr_while_full", tx_full, 1'b0);
      if (exp_q.size() == 0) chk("unexpected_tx_byte", tx_data, 64'hDEAD);
      else                   chk("tx_byte", tx_data, exp_q.pop_front());
    end
    if (frame_err) err_count++;
    if (rx_rd && rx_empty) chk("rx_rd_while_empty", rx_rd, 1'b0);
    if (alu_start) begin
      if (exp_exec_q.size() == 0) chk("unexpected_alu_start", alu_start, 1'b0);
      else                        chk("alu_operands", {alu_op, alu_a, alu_b}, exp_exec_q.pop_front());
    end
  end

  task automatic push_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    rx_q.push_back(b);
  endtask

  task automatic run_frame(input logic [7:0] op8, input logic [15:0] a, input logic [15:0] b);
    logic [17:0] r;
    if (op8[7:6] != 2'b00) begin
      exp_q.push_back(8'hEE);
      push_byte(8'hFF);
      push_byte(op8);
    end else begin
      r = alu_ref(op8[5:0], a, b);
      exp_exec_q.push_back({op8[5:0], a, b});
      exp_q.push_back(r[15:8]);
      exp_q.push_back(r[7:0]);
      exp_q.push_back({6'b0, r[17], r[16]});
      push_byte(8'hFF); push_byte(op8);
      push_byte(a[15:8]); push_byte(a[7:0]);
      push_byte(b[15:8]); push_byte(b[7:0]);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && rx_q.size() == 0 && !busy) return;
    end
    chk({name, "_idle_timeout"}, 1'b1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, e0;
    logic [7:0] op8, junk;
    rx_q.push_back(8'h55);
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_busy", busy, 0);
    chk("rst_rx_rd", rx_rd, 0);
    chk("rst_tx_wr", tx_wr, 0);
    chk("rst_alu_start", alu_start, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    reset = 1'b1;

    run_frame(8'h20, 16'h1234, 16'h0001); wait_idle("add");
    run_frame(8'h22, 16'h0005, 16'h0005); wait_idle("sub_zero");
    run_frame(8'h20, 16'hFFFF, 16'h0001); wait_idle("add_carry");

    e0 = err_count;
    exp_q.push_back(8'hEE);
    push_byte(8'hFF); push_byte(8'h20); push_byte(8'h12);
    wait_idle("timeout");
    chk("timeout_err_pulses", err_count - e0, 1);
    chk("timeout_busy", busy, 0);

    e0 = err_count;
    run_frame(8'hC0, 16'h0, 16'h0); wait_idle("bad_op");
    chk("bad_op_err_pulses", err_count - e0, 1);

    t0 = tx_count;
    push_byte(8'h55); push_byte(8'hAA);
    wait_idle("junk");
    chk("junk_no_tx", tx_count - t0, 0);
    push_byte(8'h55); push_byte(8'hAA);
    run_frame(8'h24, 16'hF0F0, 16'h3C3C); wait_idle("junk_then_and");

    t0 = tx_count;
    run_frame(8'h25, 16'h0F00, 16'h00F1);
    begin
      int i;
      for (i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (alu_start) break;
      end
      if (i == 200) chk("stall_alu_start_timeout", 1'b1, 1'b0);
    end
    tx_full_dir = 1'b1;
    repeat (20) begin @(posedge clk); #1; end
    chk("stall_no_tx_while_full", tx_count - t0, 0);
    tx_full_dir = 1'b0;
    wait_idle("stall");
    chk("stall_tx_count", tx_count - t0, 3);

    t0 = tx_count; e0 = err_count;
    push_byte(8'hFF); push_byte(8'h20); push_byte(8'h12);
    for (int i = 0; i < 20 && rx_q.size() != 0; i++) begin @(posedge clk); #1; end
    @(posedge clk); #1;
    chk("midframe_busy_before_reset", busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    rx_q.delete();
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b1;
    repeat (TO + 20) begin @(posedge clk); #1; end
    chk("midframe_reset_no_tx", tx_count - t0, 0);
    chk("midframe_reset_no_err", err_count - e0, 0);
    chk("midframe_reset_busy", busy, 0);

    rnd_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        junk = 8'($urandom_range(0, 254));
        push_byte(junk);
      end
      case ($urandom_range(0, 8))
        0: op8 = 8'h20; 1: op8 = 8'h22; 2: op8 = 8'h24; 3: op8 = 8'h25;
        4: op8 = 8'h20; 5: op8 = 8'h22;
        6: op8 = {2'($urandom_range(1, 3)), 6'($urandom_range(0, 63))};
        default: op8 = 8'h25;
      endcase
      run_frame(op8, 16'($urandom), 16'($urandom));
      wait_idle("random");
    end
    rnd_en = 1'b0;

    chk("left_expected_bytes", exp_q.size(), 0);
    chk("left_expected_execs", exp_exec_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
